// File: rtl/regfile_scrub.sv
// Integer register file for the RV32 pipeline.
// Two combinational read ports (decode side), one synchronous write port
// (writeback side) and a hardwired zero register. After reset a scrub FSM
// clears one entry per clock, so the storage array needs no bulk reset and
// can map onto distributed or block RAM. Writes are only accepted once the
// scrub has finished and `ready` is high.

module regfile_scrub #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS),
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_id,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read1_id,
   input  logic [ADDR_WIDTH-1:0] read2_id,
   output logic [DATA_WIDTH-1:0] read1_data,
   output logic [DATA_WIDTH-1:0] read2_data,
   output logic                  ready,
   output logic                  write_dropped
);

   // One extra bit so that NUM_REGS itself is representable when it equals
   // 2**ADDR_WIDTH (e.g. 64 entries on a 6-bit id).
   localparam logic [ADDR_WIDTH:0]   NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] LAST_ID      = ADDR_WIDTH'(NUM_REGS - 1);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ID      = '0;

   typedef enum logic {
      SCRUB = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   scrub_ptr;
   logic [DATA_WIDTH-1:0]   registers [NUM_REGS];

   logic                    write_in_range;
   logic                    write_accept;
   logic                    write_drop_req;
   logic                    read1_in_range;
   logic                    read2_in_range;
   logic                    bypass_on;

   // Ids at or above NUM_REGS do not exist; this matters whenever NUM_REGS
   // is not a power of two.
   assign write_in_range = ({1'b0, write_id} < NUM_REGS_EXT);
   assign read1_in_range = ({1'b0, read1_id} < NUM_REGS_EXT);
   assign read2_in_range = ({1'b0, read2_id} < NUM_REGS_EXT);

   // A write only lands in RUN, inside the array and away from x0. Writes to
   // x0 vanish quietly, but a write during the scrub or to a missing entry is
   // reported to the requester through write_dropped.
   assign write_accept   = (state == RUN) && write_en && write_in_range && (write_id != ZERO_ID);
   assign write_drop_req = write_en && ((state == SCRUB) || !write_in_range);

   assign bypass_on = (BYPASS != 0);

   // Control FSM: reset restarts the scrub at entry 0; the last scrub edge
   // moves to RUN. ready and write_dropped are registered here so neither has
   // a combinational path from the inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= SCRUB;
         scrub_ptr     <= '0;
         ready         <= 1'b0;
         write_dropped <= 1'b0;
      end else begin
         write_dropped <= write_drop_req;
         case (state)
            SCRUB: begin
               if (scrub_ptr == LAST_ID) begin
                  state     <= RUN;
                  ready     <= 1'b1;
                  scrub_ptr <= '0;
               end else begin
                  scrub_ptr <= scrub_ptr + ADDR_WIDTH'(1);
               end
            end
            RUN: begin
               ready <= 1'b1;
            end
            default: begin
               state     <= SCRUB;
               scrub_ptr <= '0;
               ready     <= 1'b0;
            end
         endcase
      end
   end

   // Storage array has a single write port and no reset so it can map onto
   // RAM; the scrub and the writeback path share that one port. Nothing is
   // written on a reset edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == SCRUB) begin
            registers[scrub_ptr] <= '0;
         end else if (write_accept) begin
            registers[write_id] <= write_data;
         end
      end
   end

   // Read port 1: zero for x0, for missing ids and while scrubbing; otherwise
   // the stored entry, or the in-flight write data when forwarding is on.
   always_comb begin
      read1_data = '0;
      if (ready && (read1_id != ZERO_ID) && read1_in_range) begin
         if (bypass_on && write_en && (write_id == read1_id)) begin
            read1_data = write_data;
         end else begin
            read1_data = registers[read1_id];
         end
      end
   end

   // Read port 2: identical selection rules to port 1, evaluated on its own id.
   always_comb begin
      read2_data = '0;
      if (ready && (read2_id != ZERO_ID) && read2_in_range) begin
         if (bypass_on && write_en && (write_id == read2_id)) begin
            read2_data = write_data;
         end else begin
            read2_data = registers[read2_id];
         end
      end
   end

endmodule

// File: tb/tb_regfile_scrub.sv
// Testbench for regfile_scrub. Three instances share one stimulus stream:
// dut_a uses defaults (BYPASS=1), dut_b has BYPASS=0 and dut_c has 24 entries.
// A reference array holds the expected contents of the 32-entry instances;
// expected read values are queued as ids are driven and popped once the
// read ports have settled.

module tb_regfile_scrub;

   logic        clk = 1'b0;
   logic        reset;
   logic        write_en;
   logic [4:0]  write_id;
   logic [31:0] write_data;
   logic [4:0]  read1_id;
   logic [4:0]  read2_id;

   logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
   logic        a_ready, b_ready, c_ready;
   logic        a_drop, b_drop, c_drop;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [32];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   regfile_scrub dut_a (
      .clk(clk), .reset(reset), .write_en(write_en), .write_id(write_id),
      .write_data(write_data), .read1_id(read1_id), .read2_id(read2_id),
      .read1_data(a_rd1), .read2_data(a_rd2), .ready(a_ready), .write_dropped(a_drop)
   );

   regfile_scrub #(.BYPASS(0)) dut_b (
      .clk(clk), .reset(reset), .write_en(write_en), .write_id(write_id),
      .write_data(write_data), .read1_id(read1_id), .read2_id(read2_id),
      .read1_data(b_rd1), .read2_data(b_rd2), .ready(b_ready), .write_dropped(b_drop)
   );

   regfile_scrub #(.NUM_REGS(24)) dut_c (
      .clk(clk), .reset(reset), .write_en(write_en), .write_id(write_id),
      .write_data(write_data), .read1_id(read1_id), .read2_id(read2_id),
      .read1_data(c_rd1), .read2_data(c_rd2), .ready(c_ready), .write_dropped(c_drop)
   );

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      $display("[TB] test_reset");
      reset = 1'b1; write_en = 1'b0; write_id = '0; write_data = '0;
      read1_id = 5'd5; read2_id = 5'd0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      repeat (3) tick();
      #1;
      checks++; if (a_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", a_ready); end
      checks++; if (a_drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_dropped got %b expected 0", a_drop); end
      checks++; if (a_rd1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_read_a got %h expected 0", a_rd1); end
      checks++; if (b_rd1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_read_b got %h expected 0", b_rd1); end
      checks++; if (c_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_c got %b expected 0", c_ready); end
      reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         #1;
         checks++;
         if (a_ready !== (k == 32)) begin
            errors++; $display("[TB] FAIL scrub_ready_a edge %0d got %b expected %b", k, a_ready, (k == 32));
         end
         checks++;
         if (c_ready !== (k >= 24)) begin
            errors++; $display("[TB] FAIL scrub_ready_c edge %0d got %b expected %b", k, c_ready, (k >= 24));
         end
      end
      for (int i = 0; i < 32; i++) begin
         tick();
         read1_id = 5'(i); read2_id = 5'(31 - i);
         exp_q.push_back(model[i]);
         exp_q.push_back(model[31 - i]);
         #1;
         exp = exp_q.pop_front();
         checks++; if (a_rd1 !== exp) begin errors++; $display("[TB] FAIL scrubbed_rd1 id %0d got %h expected %h", i, a_rd1, exp); end
         exp = exp_q.pop_front();
         checks++; if (a_rd2 !== exp) begin errors++; $display("[TB] FAIL scrubbed_rd2 id %0d got %h expected %h", 31 - i, a_rd2, exp); end
      end
   endtask

   task automatic test_reset_mid_scrub();
      logic [31:0] exp;
      $display("[TB] test_reset_mid_scrub");
      read1_id = '0; read2_id = '0; write_en = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (10) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         write_en   = (k == 4) || (k == 32);
         write_id   = (k == 4) ? 5'd7 : 5'd9;
         write_data = (k == 4) ? 32'hAAAA_0007 : 32'h9999_0009;
         tick();
         #1;
         checks++;
         if (a_ready !== (k == 32)) begin
            errors++; $display("[TB] FAIL restart_ready_a edge %0d got %b expected %b", k, a_ready, (k == 32));
         end
         checks++;
         if (c_ready !== (k >= 24)) begin
            errors++; $display("[TB] FAIL restart_ready_c edge %0d got %b expected %b", k, c_ready, (k >= 24));
         end
         if ((k == 4) || (k == 5) || (k == 32)) begin
            checks++;
            if (a_drop !== (k != 5)) begin
               errors++; $display("[TB] FAIL scrub_drop_a edge %0d got %b expected %b", k, a_drop, (k != 5));
            end
         end
         if ((k == 4) || (k == 5)) begin
            checks++;
            if (c_drop !== (k == 4)) begin
               errors++; $display("[TB] FAIL scrub_drop_c edge %0d got %b expected %b", k, c_drop, (k == 4));
            end
         end
      end
      write_en = 1'b0;
      tick();
      read1_id = 5'd7; read2_id = 5'd9;
      exp_q.push_back(model[7]); exp_q.push_back(model[9]);
      exp_q.push_back(model[7]); exp_q.push_back(model[9]);
      #1;
      checks++; if (a_drop !== 1'b0) begin errors++; $display("[TB] FAIL drop_one_cycle got %b expected 0", a_drop); end
      exp = exp_q.pop_front();
      checks++; if (a_rd1 !== exp) begin errors++; $display("[TB] FAIL scrub_write_x7_a got %h expected %h", a_rd1, exp); end
      exp = exp_q.pop_front();
      checks++; if (a_rd2 !== exp) begin errors++; $display("[TB] FAIL final_edge_write_x9_a got %h expected %h", a_rd2, exp); end
      exp = exp_q.pop_front();
      checks++; if (b_rd1 !== exp) begin errors++; $display("[TB] FAIL scrub_write_x7_b got %h expected %h", b_rd1, exp); end
      exp = exp_q.pop_front();
      checks++; if (b_rd2 !== exp) begin errors++; $display("[TB] FAIL final_edge_write_x9_b got %h expected %h", b_rd2, exp); end
   endtask

   task automatic test_write_bypass();
      logic [31:0] exp;
      $display("[TB] test_write_bypass");
      tick();
      write_en = 1'b1; write_id = 5'd5; write_data = 32'hDEAD_BEEF;
      read1_id = 5'd5; read2_id = 5'd5;
      exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF);
      exp_q.push_back(model[5]);      exp_q.push_back(model[5]);
      #1;
      exp = exp_q.pop_front();
      checks++; if (a_rd1 !== exp) begin errors++; $display("[TB] FAIL bypass_rd1 got %h expected %h", a_rd1, exp); end
      exp = exp_q.pop_front();
      checks++; if (a_rd2 !== exp) begin errors++; $display("[TB] FAIL bypass_rd2 got %h expected %h", a_rd2, exp); end
      exp = exp_q.pop_front();
      checks++; if (b_rd1 !== exp) begin errors++; $display("[TB] FAIL nobypass_rd1_old got %h expected %h", b_rd1, exp); end
      exp = exp_q.pop_front();
      checks++; if (b_rd2 !== exp) begin errors++; $display("[TB] FAIL nobypass_rd2_old got %h expected %h", b_rd2, exp); end
      model[5] = 32'hDEAD_BEEF;
      tick();
      write_en = 1'b0;
      exp_q.push_back(model[5]); exp_q.push_back(model[5]);
      #1;
      exp = exp_q.pop_front();
      checks++; if (b_rd1 !== exp) begin errors++; $display("[TB] FAIL nobypass_rd1_next got %h expected %h", b_rd1, exp); end
      exp = exp_q.pop_front();
      checks++; if (b_rd2 !== exp) begin errors++; $display("[TB] FAIL nobypass_rd2_next got %h expected %h", b_rd2, exp); end
      checks++; if (a_rd1 !== model[5]) begin errors++; $display("[TB] FAIL stored_rd1_a got %h expected %h", a_rd1, model[5]); end
      checks++; if (a_drop !== 1'b0) begin errors++; $display("[TB] FAIL write_x5_drop got %b expected 0", a_drop); end
   endtask

   task automatic test_zero_reg();
      $display("[TB] test_zero_reg");
      tick();
      write_en = 1'b1; write_id = 5'd0; write_data = 32'h1234_5678;
      read1_id = 5'd0; read2_id = 5'd0;
      #1;
      checks++; if (a_rd1 !== 32'h0) begin errors++; $display("[TB] FAIL x0_bypass_rd1 got %h expected 0", a_rd1); end
      checks++; if (a_rd2 !== 32'h0) begin errors++; $display("[TB] FAIL x0_bypass_rd2 got %h expected 0", a_rd2); end
      tick();
      write_en = 1'b0;
      #1;
      checks++; if (a_drop !== 1'b0) begin errors++; $display("[TB] FAIL x0_drop got %b expected 0", a_drop); end
      checks++; if (a_rd1 !== 32'h0) begin errors++; $display("[TB] FAIL x0_stored_a got %h expected 0", a_rd1); end
      checks++; if (b_rd2 !== 32'h0) begin errors++; $display("[TB] FAIL x0_stored_b got %h expected 0", b_rd2); end
   endtask

   task automatic test_out_of_range();
      $display("[TB] test_out_of_range");
      tick();
      write_en = 1'b1; write_id = 5'd30; write_data = 32'hCAFE_0030;
      read1_id = 5'd30; read2_id = 5'd30;
      #1;
      checks++; if (c_rd1 !== 32'h0) begin errors++; $display("[TB] FAIL oor_bypass_c got %h expected 0", c_rd1); end
      checks++; if (a_rd2 !== 32'hCAFE_0030) begin errors++; $display("[TB] FAIL x30_bypass_a got %h expected cafe0030", a_rd2); end
      model[30] = 32'hCAFE_0030;
      tick();
      write_en = 1'b0;
      #1;
      checks++; if (c_drop !== 1'b1) begin errors++; $display("[TB] FAIL oor_drop_c got %b expected 1", c_drop); end
      checks++; if (a_drop !== 1'b0) begin errors++; $display("[TB] FAIL x30_drop_a got %b expected 0", a_drop); end
      checks++; if (c_rd1 !== 32'h0) begin errors++; $display("[TB] FAIL oor_read_c got %h expected 0", c_rd1); end
      checks++; if (b_rd1 !== model[30]) begin errors++; $display("[TB] FAIL x30_read_b got %h expected %h", b_rd1, model[30]); end
      tick();
      #1;
      checks++; if (c_drop !== 1'b0) begin errors++; $display("[TB] FAIL oor_drop_clear_c got %b expected 0", c_drop); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      $display("[TB] test_back_to_back");
      tick();
      for (int i = 1; i < 32; i++) begin
         write_en = 1'b1; write_id = 5'(i); write_data = 32'(i * 3);
         model[i] = 32'(i * 3);
         tick();
         #1;
         checks++;
         if ((a_drop !== 1'b0) || (b_drop !== 1'b0)) begin
            errors++; $display("[TB] FAIL b2b_drop id %0d got %b/%b expected 0", i, a_drop, b_drop);
         end
      end
      write_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         tick();
         read1_id = 5'(i); read2_id = 5'(31 - i);
         exp_q.push_back(model[i]);      exp_q.push_back(model[31 - i]);
         exp_q.push_back(model[i]);      exp_q.push_back(model[31 - i]);
         #1;
         exp = exp_q.pop_front();
         checks++; if (a_rd1 !== exp) begin errors++; $display("[TB] FAIL b2b_rd1_a id %0d got %h expected %h", i, a_rd1, exp); end
         exp = exp_q.pop_front();
         checks++; if (a_rd2 !== exp) begin errors++; $display("[TB] FAIL b2b_rd2_a id %0d got %h expected %h", 31 - i, a_rd2, exp); end
         exp = exp_q.pop_front();
         checks++; if (b_rd1 !== exp) begin errors++; $display("[TB] FAIL b2b_rd1_b id %0d got %h expected %h", i, b_rd1, exp); end
         exp = exp_q.pop_front();
         checks++; if (b_rd2 !== exp) begin errors++; $display("[TB] FAIL b2b_rd2_b id %0d got %h expected %h", 31 - i, b_rd2, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_scrub();
      test_write_bypass();
      test_zero_reg();
      test_out_of_range();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

endmodule
